// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg
//   Shared definitions for the PLL lock sequencer:
//   - pll_state_t : sequencer state encoding
//   - DEF_*       : default sequencing parameters for a 48 MHz reference
//   - LOSS_CNT_W  : width of the saturating lock-loss counter
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } pll_state_t;

    localparam int DEF_RESET_HOLD_CYCLES   = 48;      // 1 us
    localparam int DEF_LOCK_STABLE_CYCLES  = 4800;    // 100 us
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 480000;  // 10 ms
    localparam int DEF_MAX_RETRIES         = 3;

    localparam int LOSS_CNT_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for a single asynchronous status bit.
//   No reset: the data path settles within two cycles of clock activity.
// Ports:
//   clock_in : destination clock
//   d        : asynchronous input
//   q        : synchronized output (2 cycles latency)
module sync_2ff (
    input  logic clock_in,
    input  logic d,
    output logic q
);

    logic meta_p0;

    // stage p0: capture (may go metastable), stage p1: resolved output
    always_ff @(posedge clock_in) begin
        meta_p0 <= d;
        q       <= meta_p0;
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Holds the PLL in reset, waits for and qualifies LOCK, then releases the
//   PLL-domain reset. Lock loss in RUN restarts the sequence; lock timeouts
//   are retried a bounded number of times before latching FAULT.
// Ports:
//   clock_in        : 48 MHz reference clock, all logic in this domain
//   reset           : synchronous, active-high
//   pll_locked      : raw PLL LOCK (asynchronous)
//   restart         : single-cycle relock request
//   pll_resetb      : PLL RESETB (active-low)
//   domain_reset    : active-high reset for the PLL clock domain
//   ready           : PLL qualified and domain released
//   fault           : retries exhausted
//   retry_count     : timeouts in the current sequence
//   lock_loss_count : saturating count of lock losses seen in RUN
module pll_lock_sequencer
    import pll_ctrl_pkg::*;
#(
    parameter int RESET_HOLD_CYCLES   = DEF_RESET_HOLD_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic                               clock_in,
    input  logic                               reset,
    input  logic                               pll_locked,
    input  logic                               restart,
    output logic                               pll_resetb,
    output logic                               domain_reset,
    output logic                               ready,
    output logic                               fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
    output logic [LOSS_CNT_W-1:0]              lock_loss_count
);

    localparam int HOLD_W   = $clog2(RESET_HOLD_CYCLES + 1);
    localparam int STABLE_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int TMO_W    = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int RETRY_W  = $clog2(MAX_RETRIES + 1);

    // Counters terminate one short of the parameter value so the terminal
    // cycle is the N-th cycle spent in the state.
    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);

    function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
        return (&v) ? v : v + LOSS_CNT_W'(1);
    endfunction

    pll_state_t              state, state_next;
    logic                    lock_s;
    logic [HOLD_W-1:0]       hold_cnt, hold_next;
    logic [STABLE_W-1:0]     stable_cnt, stable_next;
    logic [TMO_W-1:0]        tmo_cnt, tmo_next;
    logic [RETRY_W-1:0]      retry_next, retry_inc;
    logic [LOSS_CNT_W-1:0]   loss_next;

    sync_2ff u_lock_sync (
        .clock_in (clock_in),
        .d        (pll_locked),
        .q        (lock_s)
    );

    always_comb begin
        state_next  = state;
        hold_next   = '0;
        stable_next = '0;
        tmo_next    = tmo_cnt;
        retry_next  = retry_count;
        loss_next   = lock_loss_count;
        retry_inc   = retry_count + RETRY_W'(1);

        case (state)
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_next = ST_WAIT_LOCK;
                    tmo_next   = '0;
                end else begin
                    hold_next = hold_cnt + HOLD_W'(1);
                end
            end
            ST_WAIT_LOCK, ST_STABLE: begin
                // Timeout spans both states and wins over qualification.
                if (tmo_cnt == TMO_LAST) begin
                    retry_next = retry_inc;
                    state_next = (retry_inc < RETRY_W'(MAX_RETRIES)) ? ST_HOLD : ST_FAULT;
                    tmo_next   = '0;
                end else begin
                    tmo_next = tmo_cnt + TMO_W'(1);
                    if (state == ST_WAIT_LOCK) begin
                        if (lock_s) state_next = ST_STABLE;
                    end else if (!lock_s) begin
                        state_next = ST_WAIT_LOCK;
                    end else if (stable_cnt == STABLE_LAST) begin
                        state_next = ST_RUN;
                    end else begin
                        stable_next = stable_cnt + STABLE_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_next = ST_HOLD;
                    loss_next  = sat_inc(lock_loss_count);
                end
            end
            ST_FAULT: begin
                state_next = ST_FAULT;
            end
            default: begin
                state_next = ST_HOLD;
            end
        endcase

        // restart overrides everything, including a lock loss in the same cycle
        if (restart) begin
            state_next  = ST_HOLD;
            hold_next   = '0;
            stable_next = '0;
            tmo_next    = '0;
            retry_next  = '0;
            loss_next   = lock_loss_count;
        end
    end

    // Outputs are decoded from the next state so they change with the state register.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state           <= ST_HOLD;
            hold_cnt        <= '0;
            stable_cnt      <= '0;
            tmo_cnt         <= '0;
            retry_count     <= '0;
            lock_loss_count <= '0;
            pll_resetb      <= 1'b0;
            domain_reset    <= 1'b1;
            ready           <= 1'b0;
            fault           <= 1'b0;
        end else begin
            state           <= state_next;
            hold_cnt        <= hold_next;
            stable_cnt      <= stable_next;
            tmo_cnt         <= tmo_next;
            retry_count     <= retry_next;
            lock_loss_count <= loss_next;
            pll_resetb      <= (state_next == ST_WAIT_LOCK) || (state_next == ST_STABLE) ||
                               (state_next == ST_RUN);
            domain_reset    <= (state_next != ST_RUN);
            ready           <= (state_next == ST_RUN);
            fault           <= (state_next == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer
//   Directed stimulus pushes the expected output snapshot and the cycle at
//   which it must appear; a monitor compares every change of the DUT outputs
//   against the head of the queue.
module tb_pll_lock_sequencer;

    localparam int H = 4;
    localparam int S = 8;
    localparam int T = 32;
    localparam int R = 2;

    logic       clock_in = 1'b0;
    logic       reset = 1'b1;
    logic       pll_locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_resetb, domain_reset, ready, fault;
    logic [1:0] retry_count;
    logic [7:0] lock_loss_count;

    pll_lock_sequencer #(
        .RESET_HOLD_CYCLES   (H),
        .LOCK_STABLE_CYCLES  (S),
        .LOCK_TIMEOUT_CYCLES (T),
        .MAX_RETRIES         (R)
    ) dut (
        .clock_in        (clock_in),
        .reset           (reset),
        .pll_locked      (pll_locked),
        .restart         (restart),
        .pll_resetb      (pll_resetb),
        .domain_reset    (domain_reset),
        .ready           (ready),
        .fault           (fault),
        .retry_count     (retry_count),
        .lock_loss_count (lock_loss_count)
    );

    always #5 clock_in = ~clock_in;

    int cyc = 0;
    always @(posedge clock_in) cyc <= cyc + 1;

    typedef struct packed {
        logic       rb;
        logic       dr;
        logic       rdy;
        logic       f;
        logic [1:0] rc;
        logic [7:0] llc;
    } snap_t;

    typedef struct {
        int    at;
        string name;
        snap_t v;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         mon_en = 1'b0;
    bit         drain = 1'b0;
    bit         first = 1'b1;
    snap_t      prev;
    logic [7:0] exp_llc = 8'd0;

    function automatic snap_t mk(input logic rb, input logic dr, input logic rdy, input logic f,
                                 input logic [1:0] rc, input logic [7:0] llc);
        snap_t s;
        s.rb = rb; s.dr = dr; s.rdy = rdy; s.f = f; s.rc = rc; s.llc = llc;
        return s;
    endfunction

    function automatic snap_t s_hold(input logic [1:0] rc, input logic [7:0] llc);
        return mk(1'b0, 1'b1, 1'b0, 1'b0, rc, llc);
    endfunction
    function automatic snap_t s_wait(input logic [1:0] rc, input logic [7:0] llc);
        return mk(1'b1, 1'b1, 1'b0, 1'b0, rc, llc);
    endfunction
    function automatic snap_t s_run(input logic [1:0] rc, input logic [7:0] llc);
        return mk(1'b1, 1'b0, 1'b1, 1'b0, rc, llc);
    endfunction
    function automatic snap_t s_fault(input logic [1:0] rc, input logic [7:0] llc);
        return mk(1'b0, 1'b1, 1'b0, 1'b1, rc, llc);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock_in);
        #1;
    endtask

    task automatic push(input int d, input string nm, input snap_t v);
        exp_t e;
        e.at = cyc + d; e.name = nm; e.v = v;
        exp_q.push_back(e);
    endtask

    // From RUN: drop lock, optionally with a coincident restart, then relock.
    task automatic loss_relock(input bit with_restart, input string tag);
        if (!with_restart && exp_llc != 8'hFF) exp_llc = exp_llc + 8'd1;
        push(3,  {tag, "_hold"},  s_hold(2'd0, exp_llc));
        push(7,  {tag, "_wait"},  s_wait(2'd0, exp_llc));
        push(16, {tag, "_ready"}, s_run(2'd0, exp_llc));
        pll_locked = 1'b0;
        tick(2);
        restart = with_restart;
        tick(1);
        restart = 1'b0;
        tick(2);
        pll_locked = 1'b1;
        tick(11);
    endtask

    // From RUN: restart with lock dropped; returns at the cycle RESETB rises.
    task automatic restart_drop(input string tag);
        push(1, {tag, "_hold"}, s_hold(2'd0, exp_llc));
        push(5, {tag, "_wait"}, s_wait(2'd0, exp_llc));
        pll_locked = 1'b0;
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        tick(4);
    endtask

    always @(negedge clock_in) begin
        snap_t cur;
        exp_t  e;
        cur = {pll_resetb, domain_reset, ready, fault, retry_count, lock_loss_count};
        if (mon_en && (first || cur != prev)) begin
            first = 1'b0;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_change: cycle=%0d outputs got=%b want=none", cyc, cur);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e.v || cyc != e.at) begin
                    n_bad++;
                    $display("FAIL %s: cycle got=%0d want=%0d, outputs got=%b want=%b",
                             e.name, cyc, e.at, cur, e.v);
                end
            end
        end
        prev = cur;
        if (drain) begin
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL %s: never observed, want=%b at cycle %0d", e.name, e.v, e.at);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state, then nominal bring-up
        tick(3);
        push(0, "reset_state", s_hold(2'd0, 8'd0));
        mon_en = 1'b1;
        reset = 1'b0;
        push(4, "resetb_release", s_wait(2'd0, 8'd0));
        tick(9);
        pll_locked = 1'b1;
        push(11, "nominal_ready", s_run(2'd0, 8'd0));
        tick(11);

        // lock loss in RUN, 257 times: count saturates at 255
        for (int i = 0; i < 257; i++) loss_relock(1'b0, "lock_loss");

        // restart coinciding with lock loss: no increment
        loss_relock(1'b1, "restart_vs_loss");

        // one-cycle glitch at stable count 5
        restart_drop("glitch_seq");
        pll_locked = 1'b1;
        push(18, "glitch_ready", s_run(2'd0, exp_llc));
        tick(6);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(11);

        // long drop in STABLE: timeout counted from RESETB release, beats STABLE->RUN
        restart_drop("tmo_seq");
        pll_locked = 1'b1;
        push(32, "timeout_beats_run", s_hold(2'd1, exp_llc));
        tick(6);
        pll_locked = 1'b0;
        tick(15);
        pll_locked = 1'b1;
        tick(11);

        // second timeout with lock stuck low -> FAULT
        pll_locked = 1'b0;
        push(4,  "retry1_wait", s_wait(2'd1, exp_llc));
        push(36, "fault_entry", s_fault(2'd2, exp_llc));
        tick(36);
        pll_locked = 1'b1;
        tick(10);
        pll_locked = 1'b0;
        tick(5);

        // restart in FAULT, lock stuck low: full retry cycle back into FAULT
        push(1,  "fault_restart_hold", s_hold(2'd0, exp_llc));
        push(5,  "fault_restart_wait", s_wait(2'd0, exp_llc));
        push(37, "stuck_timeout1",     s_hold(2'd1, exp_llc));
        push(41, "stuck_retry_wait",   s_wait(2'd1, exp_llc));
        push(73, "stuck_fault",        s_fault(2'd2, exp_llc));
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        tick(72);

        // reset asserted in STABLE
        push(1, "restart2_hold", s_hold(2'd0, exp_llc));
        push(5, "restart2_wait", s_wait(2'd0, exp_llc));
        restart = 1'b1;
        pll_locked = 1'b1;
        tick(1);
        restart = 1'b0;
        tick(6);
        reset = 1'b1;
        push(1, "reset_in_stable", s_hold(2'd0, 8'd0));
        tick(1);
        reset = 1'b0;
        push(4,  "post_reset_wait",  s_wait(2'd0, 8'd0));
        push(13, "post_reset_ready", s_run(2'd0, 8'd0));
        tick(23);

        drain = 1'b1;
        @(negedge clock_in);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Sequences the iCE40 PLL (SB_PLL40_CORE wrapper) from the 48 MHz board reference clock, holding the PLL in reset, waiting for and qualifying LOCK, and only then releasing the fabric reset for the PLL-clocked domain. It detects lock loss and lock timeouts, retries a bounded number of times, and latches a fault for the ESP32-side status readout. It sits at the top level between the PLL instance and the reset synchronizers of the PLL clock domain.

## Interface
- RESET_HOLD_CYCLES, 48: cycles the PLL RESETB is held low per attempt (1 us at 48 MHz).
- LOCK_STABLE_CYCLES, 4800: consecutive synced-lock-high cycles required before release (100 us).
- LOCK_TIMEOUT_CYCLES, 480000: cycles allowed from RESETB release to qualified lock (10 ms).
- MAX_RETRIES, 3: timeouts tolerated before FAULT.
- clock_in  input  1  48 MHz reference clock; all logic in this domain. One clock; reset is synchronous and active-high.
- reset  input  1  synchronous, active-high.
- pll_locked  input  1  raw PLL LOCK, asynchronous to clock_in.
- restart  input  1  single-cycle relock request (status/SPI register).
- pll_resetb  output  1  drives PLL RESETB (active-low).
- domain_reset  output  1  active-high reset for the PLL clock domain (re-synchronized there).
- ready  output  1  PLL qualified and domain released.
- fault  output  1  retries exhausted.
- retry_count  output  $clog2(MAX_RETRIES+1)  timeouts in current sequence.
- lock_loss_count  output  8  saturating count of lock losses in RUN.

## Operation
- pll_locked passes through a 2-flop synchronizer -> lock_s; only lock_s is used.
- States: HOLD, WAIT_LOCK, STABLE, RUN, FAULT. All outputs registered, decoded from state.
- HOLD: pll_resetb=0, domain_reset=1. Count RESET_HOLD_CYCLES, then WAIT_LOCK; clear timeout counter.
- WAIT_LOCK: pll_resetb=1. lock_s=1 -> STABLE, clear stable counter.
- STABLE: lock_s=1 increments stable counter; at LOCK_STABLE_CYCLES -> RUN. lock_s=0 -> WAIT_LOCK (stable counter cleared, timeout counter NOT cleared).
- Timeout counter runs in WAIT_LOCK and STABLE; reaching LOCK_TIMEOUT_CYCLES: retry_count+1; if new value < MAX_RETRIES -> HOLD, else FAULT. Timeout takes priority over STABLE->RUN in the same cycle.
- RUN: ready=1, domain_reset=0, pll_resetb=1. lock_s=0 -> HOLD, lock_loss_count+1 (saturates at 255), retry_count unchanged.
- FAULT: pll_resetb=0, domain_reset=1, fault=1; exits only on restart or reset.
- restart=1 in any state: -> HOLD, retry_count=0, fault=0; lock_loss_count kept. restart beats every other transition, including lock loss in RUN (no lock-loss increment that cycle).
- reset: state HOLD, all counters 0, pll_resetb=0, domain_reset=1, ready=0, fault=0, retry_count=0, lock_loss_count=0. Reset mid-sequence aborts identically.

## Timing
- First cycle after reset deassert is HOLD cycle 1; pll_resetb rises after exactly RESET_HOLD_CYCLES HOLD cycles.
- pll_locked edge -> lock_s: 2 cycles; lock_s -> state change: 1 cycle; registered outputs follow state in the same cycle as state.
- Minimum RESETB-high-to-ready latency: 2 + 1 + LOCK_STABLE_CYCLES cycles after pll_locked rises.
- Lock loss in RUN: ready/domain_reset change 3 cycles after pll_locked falls.
- Counters sized $clog2(param+1); no wrap on any counter.

## Structure
- Package pll_ctrl_pkg: state encoding constants, default parameter values, lock_loss_count width.
- Sub-module sync_2ff (1-bit, clock_in, no reset on data path) for pll_locked; reused for other async status inputs.
- FSM, three counters and output register in pll_lock_sequencer.

## Test plan
Bench params: RESET_HOLD=4, STABLE=8, TIMEOUT=32, MAX_RETRIES=2.
- Nominal: pll_locked rises 5 cycles after pll_resetb rises, held -> ready=1, domain_reset=0 exactly 11 cycles after pll_locked rise; fault=0, retry_count=0.
- Glitch in STABLE: lock low 1 cycle at stable count 5 -> back to WAIT_LOCK, ready only after 8 further consecutive high cycles; timeout still counted from RESETB release.
- Timeout: pll_locked stuck 0 -> retry_count=1 after 32 WAIT_LOCK cycles, pll_resetb low 4 cycles, second timeout -> FAULT, fault=1, pll_resetb=0.
- Lock loss in RUN: drop pll_locked -> 3 cycles later ready=0, domain_reset=1, lock_loss_count=1; relock recovers; 256 losses -> count stays 255.
- restart in FAULT and restart coinciding with lock loss in RUN -> HOLD, retry_count=0, fault=0, lock_loss_count unchanged.
- Reset asserted in STABLE -> next cycle all outputs at reset values, pll_resetb=0.
